// File: rtl/jtopl_eg_pkg.sv
// Shared constants for the envelope slot storage: one-hot state codes,
// slot count and widths.
package jtopl_eg_pkg;

   localparam int EG_SLOTS = 18;
   localparam int EG_W     = 10;
   localparam int EG_CNTW  = 15;
   localparam int EG_SLOTW = 5;

   typedef enum logic [2:0] {
      EG_ATTACK  = 3'b001,
      EG_DECAY   = 3'b010,
      EG_RELEASE = 3'b100
   } eg_state_e;

   localparam logic [EG_W-1:0] EG_MAX_ATT = 10'h3FF;

endpackage

// File: rtl/jtopl_eg_sh.sv
// Clock-enabled circular-style shift register: din enters stage 0, dout is the
// last stage, so a value written now reappears after STAGES enabled edges.
module jtopl_eg_sh #(
   parameter int               WIDTH   = 1,
   parameter int               STAGES  = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             rst_n,
   input  logic             clk,
   input  logic             cen,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] sh_q [STAGES];
   logic [WIDTH-1:0] sh_d [STAGES];

   always_comb begin
      for (int i = 0; i < STAGES; i++) begin
         sh_d[i] = sh_q[i];
      end
      if (cen) begin
         sh_d[0] = din;
         for (int i = 1; i < STAGES; i++) begin
            sh_d[i] = sh_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            sh_q[i] <= RST_VAL;
         end
      end else begin
         for (int i = 0; i < STAGES; i++) begin
            sh_q[i] <= sh_d[i];
         end
      end
   end

   assign dout = sh_q[STAGES-1];

endmodule

// File: rtl/jtopl_eg_slots.sv
// Per-slot envelope storage, slot sequencer and global envelope counter.
// Optional debug tap on one slot's attenuation: define JTOPL_EG_DEBUG_EN.
module jtopl_eg_slots
   import jtopl_eg_pkg::*;
#(
   parameter int SLOTS = EG_SLOTS,
   parameter int EGW   = EG_W,
   parameter int CNTW  = EG_CNTW
) (
   input  logic            rst_n,
   input  logic            clk,
   input  logic            cen,
   input  logic            keyon,
   input  logic [2:0]      state_next,
   input  logic [EGW-1:0]  eg_next,
   input  logic            cnt_lsb,
   output logic            keyon_now,
   output logic            keyoff_now,
   output logic [2:0]      state_in,
   output logic [EGW-1:0]  eg_in,
   output logic            cnt_in,
   output logic [CNTW-1:0] eg_cnt,
   output logic [4:0]      slot,
   output logic            zero
`ifdef JTOPL_EG_DEBUG_EN
   ,
   input  logic [4:0]      dbg_slot,
   output logic [EGW-1:0]  dbg_eg
`endif
);

   // Entry layout, MSB first: {state, eg, kprev, cnt}
   localparam int               ENTW    = 3 + EGW + 2;
   localparam logic [ENTW-1:0]  ENT_RST = {EG_RELEASE, {EGW{1'b1}}, 1'b0, 1'b0};
   localparam logic [4:0]       LAST    = 5'(SLOTS - 1);

   logic [ENTW-1:0] wr_ent;
   logic [ENTW-1:0] head;
   logic            kprev;

   assign wr_ent = {state_next, eg_next, keyon, cnt_lsb};

   jtopl_eg_sh #(
      .WIDTH   (ENTW),
      .STAGES  (SLOTS),
      .RST_VAL (ENT_RST)
   ) u_sh (
      .rst_n (rst_n),
      .clk   (clk),
      .cen   (cen),
      .din   (wr_ent),
      .dout  (head)
   );

   assign state_in = head[ENTW-1 -: 3];
   assign eg_in    = head[EGW+1 -: EGW];
   assign kprev    = head[1];
   assign cnt_in   = head[0];

   assign keyon_now  =  keyon & ~kprev;
   assign keyoff_now = ~keyon &  kprev;

   logic [4:0]      slot_q,   slot_d;
   logic [CNTW-1:0] eg_cnt_q, eg_cnt_d;

   always_comb begin
      slot_d   = slot_q;
      eg_cnt_d = eg_cnt_q;
      if (cen) begin
         if (slot_q == LAST) begin
            slot_d   = 5'd0;
            eg_cnt_d = eg_cnt_q + CNTW'(1);
         end else begin
            slot_d   = slot_q + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q   <= 5'd0;
         eg_cnt_q <= '0;
      end else begin
         slot_q   <= slot_d;
         eg_cnt_q <= eg_cnt_d;
      end
   end

   assign slot   = slot_q;
   assign zero   = (slot_q == 5'd0);
   assign eg_cnt = eg_cnt_q;

`ifdef JTOPL_EG_DEBUG_EN
   // Out-of-range dbg_slot never matches slot_q, so the tap simply holds.
   logic [EGW-1:0] dbg_eg_q, dbg_eg_d;

   always_comb begin
      dbg_eg_d = dbg_eg_q;
      if (cen && (slot_q == dbg_slot)) begin
         dbg_eg_d = eg_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dbg_eg_q <= {EGW{1'b1}};
      end else begin
         dbg_eg_q <= dbg_eg_d;
      end
   end

   assign dbg_eg = dbg_eg_q;
`endif

endmodule

// File: tb/tb_jtopl_eg_slots.sv
// Self-checking bench for jtopl_eg_slots: an 18-deep expected-entry queue
// (pushed on write-back, popped on presentation) plus a keyon edge table.
module tb_jtopl_eg_slots;
   import jtopl_eg_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cen = 1'b0;
   logic        keyon = 1'b0;
   logic [2:0]  state_next = 3'b100;
   logic [9:0]  eg_next = 10'h3FF;
   logic        cnt_lsb = 1'b0;
   logic        keyon_now, keyoff_now, cnt_in, zero;
   logic [2:0]  state_in;
   logic [9:0]  eg_in;
   logic [14:0] eg_cnt;
   logic [4:0]  slot;
   // second instance with a short counter so the wrap is reachable quickly
   logic        keyon_now_s, keyoff_now_s, cnt_in_s, zero_s;
   logic [2:0]  state_in_s;
   logic [9:0]  eg_in_s;
   logic [3:0]  eg_cnt_s;
   logic [4:0]  slot_s;
`ifdef JTOPL_EG_DEBUG_EN
   logic [4:0]  dbg_slot = 5'd3;
   logic [9:0]  dbg_eg, dbg_eg_s;
`endif

   always #5 clk = ~clk;

   jtopl_eg_slots dut (
      .rst_n(rst_n), .clk(clk), .cen(cen), .keyon(keyon),
      .state_next(state_next), .eg_next(eg_next), .cnt_lsb(cnt_lsb),
      .keyon_now(keyon_now), .keyoff_now(keyoff_now), .state_in(state_in),
      .eg_in(eg_in), .cnt_in(cnt_in), .eg_cnt(eg_cnt), .slot(slot), .zero(zero)
`ifdef JTOPL_EG_DEBUG_EN
      , .dbg_slot(dbg_slot), .dbg_eg(dbg_eg)
`endif
   );

   jtopl_eg_slots #(.CNTW(4)) dut_s (
      .rst_n(rst_n), .clk(clk), .cen(cen), .keyon(keyon),
      .state_next(state_next), .eg_next(eg_next), .cnt_lsb(cnt_lsb),
      .keyon_now(keyon_now_s), .keyoff_now(keyoff_now_s), .state_in(state_in_s),
      .eg_in(eg_in_s), .cnt_in(cnt_in_s), .eg_cnt(eg_cnt_s), .slot(slot_s), .zero(zero_s)
`ifdef JTOPL_EG_DEBUG_EN
      , .dbg_slot(dbg_slot), .dbg_eg(dbg_eg_s)
`endif
   );

   typedef struct packed {
      logic [2:0] st;
      logic [9:0] eg;
      logic       kp;
      logic       cn;
   } ent_t;

   typedef struct {
      logic kon_in;
      int   exp_kon;
      int   exp_koff;
   } vec_t;

   localparam ent_t ENT_RST = '{st: 3'b100, eg: 10'h3FF, kp: 1'b0, cn: 1'b0};

   ent_t       sb[$];
   vec_t       tbl[72];
   int         m_slot, m_cnt, m_cnt_s;
   logic [9:0] m_dbg;
   int         n_chk = 0;
   int         n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb.delete();
      repeat (18) sb.push_back(ENT_RST);
      m_slot  = 0;
      m_cnt   = 0;
      m_cnt_s = 0;
      m_dbg   = 10'h3FF;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_state_in"}, 32'(state_in), 32'h4);
      chk({tag, "_eg_in"}, 32'(eg_in), 32'h3FF);
      chk({tag, "_cnt_in"}, 32'(cnt_in), 32'h0);
      chk({tag, "_keyon_now"}, 32'(keyon_now), 32'(keyon));
      chk({tag, "_keyoff_now"}, 32'(keyoff_now), 32'h0);
      chk({tag, "_slot"}, 32'(slot), 32'h0);
      chk({tag, "_zero"}, 32'(zero), 32'h1);
      chk({tag, "_eg_cnt"}, 32'(eg_cnt), 32'h0);
      chk({tag, "_eg_cnt_s"}, 32'(eg_cnt_s), 32'h0);
`ifdef JTOPL_EG_DEBUG_EN
      chk({tag, "_dbg_eg"}, 32'(dbg_eg), 32'h3FF);
`endif
   endtask

   // Entered 1 time unit after a rising edge; returns 1 unit after the next one.
   task automatic cycle(input logic c, input logic k, input logic [2:0] sn,
                        input logic [9:0] en, input logic cl,
                        input int x_kon = -1, input int x_koff = -1,
                        input int x_eg = -1, input int x_st = -1);
      ent_t h;
      cen = c; keyon = k; state_next = sn; eg_next = en; cnt_lsb = cl;
      #1;
      h = sb[0];
      chk("state_in", 32'(state_in), 32'(h.st));
      chk("eg_in", 32'(eg_in), 32'(h.eg));
      chk("cnt_in", 32'(cnt_in), 32'(h.cn));
      chk("keyon_now", 32'(keyon_now), 32'(k & ~h.kp));
      chk("keyoff_now", 32'(keyoff_now), 32'(~k & h.kp));
      chk("slot", 32'(slot), 32'(m_slot));
      chk("zero", 32'(zero), 32'(m_slot == 0));
      chk("eg_cnt", 32'(eg_cnt), 32'(m_cnt));
      chk("eg_cnt_s", 32'(eg_cnt_s), 32'(m_cnt_s));
`ifdef JTOPL_EG_DEBUG_EN
      chk("dbg_eg", 32'(dbg_eg), 32'(m_dbg));
`endif
      if (x_kon >= 0)  chk("tbl_keyon_now", 32'(keyon_now), 32'(x_kon));
      if (x_koff >= 0) chk("tbl_keyoff_now", 32'(keyoff_now), 32'(x_koff));
      if (x_eg >= 0)   chk("frame_eg_in", 32'(eg_in), 32'(x_eg));
      if (x_st >= 0)   chk("frame_state_in", 32'(state_in), 32'(x_st));
      if (c) begin
         $display("txn slot=%0d keyon=%0b st_in=%b eg_in=%h wr_st=%b wr_eg=%h eg_cnt=%0d",
                  m_slot, k, state_in, eg_in, sn, en, eg_cnt);
         void'(sb.pop_front());
         sb.push_back('{st: sn, eg: en, kp: k, cn: cl});
`ifdef JTOPL_EG_DEBUG_EN
         if (32'(dbg_slot) == m_slot) m_dbg = en;
`endif
         if (m_slot == 17) begin
            m_cnt   = (m_cnt + 1) & 32'h7FFF;
            m_cnt_s = (m_cnt_s + 1) & 32'hF;
            m_slot  = 0;
         end else begin
            m_slot = m_slot + 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int guard;
      logic c;

      for (int i = 0; i < 72; i++) begin
         tbl[i].kon_in   = ((i % 18) == 5) && ((i / 18) == 1 || (i / 18) == 2);
         tbl[i].exp_kon  = (((i % 18) == 5) && ((i / 18) == 1)) ? 1 : 0;
         tbl[i].exp_koff = (((i % 18) == 5) && ((i / 18) == 3)) ? 1 : 0;
      end

      // power-on reset
      repeat (2) @(posedge clk);
      #2;
      check_reset("por");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      model_reset();

      // two idle frames
      for (int i = 0; i < 36; i++) cycle(1'b1, 1'b0, 3'b100, 10'h3FF, 1'b0);
      chk("idle_slot", 32'(slot), 32'h0);
      chk("idle_eg_cnt", 32'(eg_cnt), 32'h2);

      // key edges on slot 5 across four frames
      for (int i = 0; i < 72; i++)
         cycle(1'b1, tbl[i].kon_in, 3'b010, 10'($urandom), 1'($urandom),
               tbl[i].exp_kon, tbl[i].exp_koff);

      // distinct per-slot write-back, read back one frame later
      for (int s = 0; s < 18; s++) cycle(1'b1, 1'b0, 3'b001, 10'(s * 10), 1'b0);
      for (int s = 0; s < 18; s++)
         cycle(1'b1, 1'b0, 3'b010, 10'($urandom), 1'($urandom), -1, -1, s * 10, 1);

      // random clock enable: queue only advances on enabled edges
      for (int i = 0; i < 400; i++) begin
         c = 1'($urandom);
         cycle(c, 1'($urandom), 3'($urandom), 10'($urandom), 1'($urandom));
      end

      // counter wrap on the short-counter instance
      guard = 0;
      while (!(m_cnt_s == 15 && m_slot == 17) && guard < 400) begin
         cycle(1'b1, 1'b0, 3'b100, 10'($urandom), 1'b0);
         guard++;
      end
      chk("wrap_reached", 32'(guard < 400), 32'h1);
      chk("wrap_pre", 32'(eg_cnt_s), 32'hF);
      cycle(1'b1, 1'b0, 3'b100, 10'($urandom), 1'b0);
      chk("wrap_post", 32'(eg_cnt_s), 32'h0);
      chk("wrap_post_slot", 32'(slot), 32'h0);

      // asynchronous reset in the middle of a frame
      guard = 0;
      while (m_slot != 9 && guard < 20) begin
         cycle(1'b1, 1'($urandom), 3'b001, 10'($urandom), 1'($urandom));
         guard++;
      end
      chk("mid_slot9", 32'(slot), 32'h9);
      cen = 1'b0;
      keyon = 1'b1;
      rst_n = 1'b0;
      #1;
      check_reset("mid");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 40; i++)
         cycle(1'b1, 1'($urandom), 3'b010, 10'($urandom), 1'($urandom));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
